// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with fixed-latency logic/add ops and bit-serial shift/rotate.
// Define ALU_SEQ_LED_EN to toggle the leds indicator on every invalid command.
module alu_seq #(
    parameter int unsigned WIDTH          = 8,
    parameter string       INPUT_PRIORITY = "A",
    parameter string       FULL_ADDER     = "ON",
    parameter int unsigned LED_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                opcode,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    input  logic                      cin,
    input  logic                      serial_in,
    input  logic                      direction,
    input  logic                      red_op_A,
    input  logic                      red_op_B,
    input  logic                      bypass_A,
    input  logic                      bypass_B,
    input  logic [$clog2(WIDTH)-1:0]  shamt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   out,
    output logic                      carry_out,
    output logic                      err,
    output logic [LED_W-1:0]          leds
);

    localparam int unsigned SW      = $clog2(WIDTH);
    localparam bit          PRIO_B  = (INPUT_PRIORITY == "B");
    localparam bit          ADD_CIN = (FULL_ADDER == "ON");

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_work;
    logic [SW-1:0]      r_cnt;
    logic               r_cin;
    logic               r_sin;
    logic               r_dir;
    logic               r_red_a;
    logic               r_red_b;
    logic               r_byp_a;
    logic               r_byp_b;

    logic               w_invalid;
    logic               w_bypass;
    logic               w_multi;
    logic               w_red_bit;
    logic               w_fill;
    logic               w_carry;
    logic [WIDTH-1:0]   w_red_src;
    logic [WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH:0]     w_sum;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);

    // Result of the captured command for the EXEC cycle
    always_comb begin
        w_invalid = ((r_red_a | r_red_b) & (r_op[1] | r_op[2])) | (r_op == 3'd6) | (r_op == 3'd7);
        w_bypass  = r_byp_a | r_byp_b;
        w_multi   = !w_invalid && !w_bypass && ((r_op == 3'd4) || (r_op == 3'd5)) && (r_cnt != '0);
        w_red_src = (r_red_b && (!r_red_a || PRIO_B)) ? r_b : r_a;
        w_sum     = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, (ADD_CIN & r_cin)};
        w_red_bit = 1'b0;
        w_result  = '0;
        w_carry   = 1'b0;
        case (r_op)
            3'd0:    w_red_bit = |w_red_src;
            3'd1:    w_red_bit = ^w_red_src;
            3'd2:    w_red_bit = &w_red_src;
            default: w_red_bit = 1'b0;
        endcase
        if (!w_invalid) begin
            if (w_bypass) begin
                w_result = (r_byp_b && (!r_byp_a || PRIO_B)) ? r_b : r_a;
            end else if (r_red_a | r_red_b) begin
                w_result = {{(WIDTH-1){1'b0}}, w_red_bit};
            end else begin
                case (r_op)
                    3'd0:    w_result = r_a & r_b;
                    3'd1:    w_result = r_a | r_b;
                    3'd2:    w_result = r_a ^ r_b;
                    3'd3: begin
                        w_result = w_sum[WIDTH-1:0];
                        w_carry  = w_sum[WIDTH];
                    end
                    default: w_result = r_a;
                endcase
            end
        end
    end

    // One-bit shift step; opcode bit 0 distinguishes rotate from shift
    always_comb begin
        w_fill    = 1'b0;
        w_shifted = '0;
        if (r_dir) begin
            w_fill    = r_op[0] ? r_work[WIDTH-1] : r_sin;
            w_shifted = {r_work[WIDTH-2:0], w_fill};
        end else begin
            w_fill    = r_op[0] ? r_work[0] : r_sin;
            w_shifted = {w_fill, r_work[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_work    <= '0;
            r_cnt     <= '0;
            r_cin     <= 1'b0;
            r_sin     <= 1'b0;
            r_dir     <= 1'b0;
            r_red_a   <= 1'b0;
            r_red_b   <= 1'b0;
            r_byp_a   <= 1'b0;
            r_byp_b   <= 1'b0;
            out       <= '0;
            carry_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op    <= opcode;
                        r_a     <= A;
                        r_b     <= B;
                        r_work  <= A;
                        r_cnt   <= shamt;
                        r_cin   <= cin;
                        r_sin   <= serial_in;
                        r_dir   <= direction;
                        r_red_a <= red_op_A;
                        r_red_b <= red_op_B;
                        r_byp_a <= bypass_A;
                        r_byp_b <= bypass_B;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (w_multi) begin
                        r_state <= SHIFT;
                    end else begin
                        out       <= w_result;
                        carry_out <= w_carry;
                        err       <= w_invalid;
                        r_state   <= DONE;
                    end
                end
                SHIFT: begin
                    r_work <= w_shifted;
                    r_cnt  <= r_cnt - SW'(1);
                    if (r_cnt == SW'(1)) begin
                        out       <= w_shifted;
                        carry_out <= 1'b0;
                        err       <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_LED_EN
    logic [LED_W-1:0] r_leds;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_leds <= '0;
        end else if ((r_state == EXEC) && w_invalid) begin
            r_leds <= ~r_leds;
        end
    end

    assign leds = r_leds;
`else
    assign leds = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven scoreboard bench for alu_seq plus stall and mid-shift reset sequences.
module tb_alu_seq;

    localparam int unsigned W     = 8;
    localparam int unsigned LED_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             cin;
    logic             serial_in;
    logic             direction;
    logic             red_op_A;
    logic             red_op_B;
    logic             bypass_A;
    logic             bypass_B;
    logic [2:0]       shamt;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     dut_out;
    logic             carry_out;
    logic             err;
    logic [LED_W-1:0] leds;

    alu_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .serial_in (serial_in),
        .direction (direction),
        .red_op_A  (red_op_A),
        .red_op_B  (red_op_B),
        .bypass_A  (bypass_A),
        .bypass_B  (bypass_B),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dut_out),
        .carry_out (carry_out),
        .err       (err),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    // f = {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}
    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [6:0]   f;
        logic [2:0]   sh;
        logic [W-1:0] eo;
        logic         ec;
        logic         ee;
        logic [4:0]   lat;
    } vec_t;

    typedef struct packed {
        logic [W-1:0]     out;
        logic             c;
        logic             e;
        logic [LED_W-1:0] leds;
    } exp_t;

    vec_t             vecs[$];
    exp_t             sb[$];
    logic [LED_W-1:0] exp_leds = '0;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [6:0] f, input logic [2:0] sh, input logic [W-1:0] eo,
                                input logic ec, input logic ee, input logic [4:0] lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.f = f; v.sh = sh;
        v.eo = eo; v.ec = ec; v.ee = ee; v.lat = lat;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        opcode = v.op;
        A      = v.a;
        B      = v.b;
        shamt  = v.sh;
        {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B} = v.f;
    endtask

    // Issue one command, measure latency, compare against the scoreboard head
    task automatic run_vec(input vec_t v, input int idx);
        int   edges;
        bit   busy_rdy;
        exp_t e;
        @(negedge clk);
        check($sformatf("v%0d in_ready idle", idx), in_ready, 1);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
`ifdef ALU_SEQ_LED_EN
        if (v.ee) exp_leds = ~exp_leds;
`endif
        e.out = v.eo; e.c = v.ec; e.e = v.ee; e.leds = exp_leds;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges    = 1;
        busy_rdy = 1'b0;
        while (!out_valid && edges < 40) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        if (in_ready) busy_rdy = 1'b1;
        check($sformatf("v%0d out_valid", idx), out_valid, 1);
        check($sformatf("v%0d latency", idx), edges, v.lat);
        check($sformatf("v%0d in_ready busy", idx), busy_rdy, 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("v%0d out", idx), dut_out, e.out);
            check($sformatf("v%0d carry", idx), carry_out, e.c);
            check($sformatf("v%0d err", idx), err, e.e);
            check($sformatf("v%0d leds", idx), leds, e.leds);
        end else begin
            check($sformatf("v%0d scoreboard empty", idx), 0, 1);
        end
        @(posedge clk); #1;
        check($sformatf("v%0d back to idle", idx), in_ready, 1);
    endtask

    initial begin
        int bad;
        int edges;
        vec_t v;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; A = '0; B = '0; cin = 0; serial_in = 0; direction = 0;
        red_op_A = 0; red_op_B = 0; bypass_A = 0; bypass_B = 0; shamt = '0;

        // Add
        vecs.push_back(mk(3'd3, 8'h7F, 8'h01, 7'b1000000, 3'd0, 8'h81, 1'b0, 1'b0, 5'd2));
        vecs.push_back(mk(3'd3, 8'hFF, 8'h01, 7'b0000000, 3'd0, 8'h00, 1'b1, 1'b0, 5'd2));
        vecs.push_back(mk(3'd3, 8'h80, 8'h80, 7'b1000000, 3'd0, 8'h01, 1'b1, 1'b0, 5'd2));
        vecs.push_back(mk(3'd3, 8'hFF, 8'h00, 7'b1000000, 3'd0, 8'h00, 1'b1, 1'b0, 5'd2));
        // Bitwise
        vecs.push_back(mk(3'd0, 8'hF0, 8'h3C, 7'b0000000, 3'd0, 8'h30, 1'b0, 1'b0, 5'd2));
        vecs.push_back(mk(3'd1, 8'hF0, 8'h0F, 7'b0000000, 3'd0, 8'hFF, 1'b0, 1'b0, 5'd2));
        vecs.push_back(mk(3'd2, 8'hAA, 8'hFF, 7'b0000000, 3'd0, 8'h55, 1'b0, 1'b0, 5'd2));
        // Shift / rotate
        vecs.push_back(mk(3'd4, 8'h81, 8'h00, 7'b0110000, 3'd3, 8'h0F, 1'b0, 1'b0, 5'd5));
        vecs.push_back(mk(3'd4, 8'h80, 8'h00, 7'b0000000, 3'd2, 8'h20, 1'b0, 1'b0, 5'd4));
        vecs.push_back(mk(3'd4, 8'h00, 8'h00, 7'b0100000, 3'd4, 8'hF0, 1'b0, 1'b0, 5'd6));
        vecs.push_back(mk(3'd5, 8'h01, 8'h00, 7'b0000000, 3'd1, 8'h80, 1'b0, 1'b0, 5'd3));
        vecs.push_back(mk(3'd5, 8'h01, 8'h00, 7'b0000000, 3'd0, 8'h01, 1'b0, 1'b0, 5'd2));
        vecs.push_back(mk(3'd5, 8'h81, 8'h00, 7'b0010000, 3'd7, 8'hC0, 1'b0, 1'b0, 5'd9));
        // Reductions
        vecs.push_back(mk(3'd0, 8'h10, 8'h00, 7'b0001000, 3'd0, 8'h01, 1'b0, 1'b0, 5'd2));
        vecs.push_back(mk(3'd1, 8'h00, 8'h07, 7'b0000100, 3'd0, 8'h01, 1'b0, 1'b0, 5'd2));
        vecs.push_back(mk(3'd0, 8'h01, 8'h00, 7'b0001100, 3'd0, 8'h01, 1'b0, 1'b0, 5'd2));
        vecs.push_back(mk(3'd1, 8'h03, 8'h00, 7'b0001000, 3'd0, 8'h00, 1'b0, 1'b0, 5'd2));
        // Invalid commands
        vecs.push_back(mk(3'd2, 8'hFF, 8'hFF, 7'b1001000, 3'd0, 8'h00, 1'b0, 1'b1, 5'd2));
        vecs.push_back(mk(3'd6, 8'h12, 8'h34, 7'b0000000, 3'd0, 8'h00, 1'b0, 1'b1, 5'd2));
        vecs.push_back(mk(3'd7, 8'hFF, 8'hFF, 7'b1000000, 3'd0, 8'h00, 1'b0, 1'b1, 5'd2));
        vecs.push_back(mk(3'd4, 8'h81, 8'h00, 7'b0010100, 3'd3, 8'h00, 1'b0, 1'b1, 5'd2));
        // Bypass
        vecs.push_back(mk(3'd3, 8'h12, 8'h34, 7'b0000010, 3'd0, 8'h12, 1'b0, 1'b0, 5'd2));
        vecs.push_back(mk(3'd4, 8'h12, 8'h34, 7'b0000001, 3'd5, 8'h34, 1'b0, 1'b0, 5'd2));
        vecs.push_back(mk(3'd1, 8'h12, 8'h34, 7'b0000011, 3'd0, 8'h12, 1'b0, 1'b0, 5'd2));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out", dut_out, 0);
        check("rst carry", carry_out, 0);
        check("rst err", err, 0);
        check("rst leds", leds, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Output stall: result held, new commands ignored
        @(negedge clk);
        drive(mk(3'd3, 8'h7F, 8'h01, 7'b1000000, 3'd0, 8'h81, 1'b0, 1'b0, 5'd2));
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        A = 8'h55;
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("stall latency", edges, 2);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (!out_valid || dut_out !== 8'h81 || carry_out !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        check("stall hold", bad, 0);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        check("stall release out_valid", out_valid, 0);
        check("stall release in_ready", in_ready, 1);
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        check("stall no stray accept", bad, 0);

        // Reset in the middle of a long rotate
        @(negedge clk);
        drive(mk(3'd5, 8'h81, 8'h00, 7'b0010000, 3'd7, 8'hC0, 1'b0, 1'b0, 5'd9));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midshift busy", in_ready, 0);
        rst = 1'b1;
        #1;
        exp_leds = '0;
        check("midshift rst out", dut_out, 0);
        check("midshift rst carry", carry_out, 0);
        check("midshift rst err", err, 0);
        check("midshift rst leds", leds, exp_leds);
        check("midshift rst out_valid", out_valid, 0);
        check("midshift rst in_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        check("midshift no out_valid", bad, 0);

        v = mk(3'd5, 8'h81, 8'h00, 7'b0010000, 3'd7, 8'hC0, 1'b0, 1'b0, 5'd9);
        run_vec(v, 100);
        v = mk(3'd2, 8'hFF, 8'hFF, 7'b0001000, 3'd0, 8'h00, 1'b0, 1'b1, 5'd2);
        run_vec(v, 101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
